// File: rtl/sdram_wfifo_feeder.sv
// sdram_wfifo_feeder
//   Upstream stage of the SDRAM write path. Frames a raw pixel stream into
//   H_ACTIVE x V_ACTIVE frames and pushes accepted pixels into the SDRAM
//   controller's write FIFO once SDRAM initialisation has completed.
//
//   Build option: define WFEED_TEST_PATTERN_EN to replace pixel data with a
//   column ramp (low DW bits of the column index) for read-back checks.
//
//   Ports
//     sclk        system clock (shared with SDRAM controller)
//     rst_n       synchronous active-low reset
//     ini_end     SDRAM init complete (level)
//     vs_in       start-of-frame pulse
//     pix_valid   pixel qualifier
//     pix_data    pixel value
//     wfifo_full  write FIFO full
//     wfifo_en    FIFO push strobe, one cycle after acceptance
//     wfifo_data  FIFO push data
//     line_done   pulse with the push of the last pixel of a line
//     frame_done  pulse with the push of the last pixel of a frame
//     col_cnt     column of the next pixel to be accepted
//     row_cnt     row of the next pixel to be accepted
//     busy        high while in ACTIVE
//     err_ovf     sticky overflow flag, cleared only by reset
//
//   state    | meaning
//   WAIT_INI | SDRAM not initialised, input ignored
//   WAIT_SOF | waiting for vs_in, input ignored
//   ACTIVE   | accepting and pushing pixels
//   DROP     | overflow seen, discard until next vs_in
module sdram_wfifo_feeder #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DW       = 8,
    parameter int CW       = 10
) (
    input  logic          sclk,
    input  logic          rst_n,
    input  logic          ini_end,
    input  logic          vs_in,
    input  logic          pix_valid,
    input  logic [DW-1:0] pix_data,
    input  logic          wfifo_full,
    output logic          wfifo_en,
    output logic [DW-1:0] wfifo_data,
    output logic          line_done,
    output logic          frame_done,
    output logic [CW-1:0] col_cnt,
    output logic [CW-1:0] row_cnt,
    output logic          busy,
    output logic          err_ovf
);

    typedef enum logic [1:0] {WAIT_INI, WAIT_SOF, ACTIVE, DROP} state_t;

    localparam logic [CW-1:0] COL_MAX = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] ROW_MAX = CW'(V_ACTIVE - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] col_nxt, row_nxt;
    logic [CW-1:0] col_eff, row_eff;
    logic [DW-1:0] data_nxt;
    logic          en_nxt, ld_nxt, fd_nxt, err_nxt;
    logic          running, col_last, row_last;

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state      <= WAIT_INI;
            col_cnt    <= '0;
            row_cnt    <= '0;
            wfifo_en   <= 1'b0;
            wfifo_data <= '0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            state      <= state_nxt;
            col_cnt    <= col_nxt;
            row_cnt    <= row_nxt;
            wfifo_en   <= en_nxt;
            wfifo_data <= data_nxt;
            line_done  <= ld_nxt;
            frame_done <= fd_nxt;
            err_ovf    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col_cnt;
        row_nxt   = row_cnt;
        data_nxt  = wfifo_data;
        en_nxt    = 1'b0;
        ld_nxt    = 1'b0;
        fd_nxt    = 1'b0;
        err_nxt   = err_ovf;
        running   = 1'b0;

        // vs_in restarts the position before the concurrent pixel is judged,
        // so that pixel lands at col 0, row 0 of the new frame.
        col_eff  = vs_in ? '0 : col_cnt;
        row_eff  = vs_in ? '0 : row_cnt;
        col_last = (col_eff == COL_MAX);
        row_last = (row_eff == ROW_MAX);

        if (!ini_end) begin
            state_nxt = WAIT_INI;
        end else begin
            case (state)
                WAIT_INI:       state_nxt = WAIT_SOF;
                WAIT_SOF, DROP: running   = vs_in;
                ACTIVE:         running   = 1'b1;
                default:        state_nxt = WAIT_INI;
            endcase
        end

        if (running) begin
            state_nxt = ACTIVE;
            col_nxt   = col_eff;
            row_nxt   = row_eff;
            if (pix_valid) begin
                if (wfifo_full) begin
                    state_nxt = DROP;
                    err_nxt   = 1'b1;
                end else begin
                    en_nxt = 1'b1;
`ifdef WFEED_TEST_PATTERN_EN
                    data_nxt = DW'(col_eff);
`else
                    data_nxt = pix_data;
`endif
                    ld_nxt = col_last;
                    fd_nxt = col_last && row_last;
                    if (col_last) begin
                        col_nxt = '0;
                        if (row_last) begin
                            row_nxt   = '0;
                            state_nxt = WAIT_SOF;
                        end else begin
                            row_nxt = row_eff + 1'b1;
                        end
                    end else begin
                        col_nxt = col_eff + 1'b1;
                    end
                end
            end
        end
    end

    assign busy = (state == ACTIVE);

endmodule

// File: tb/tb_sdram_wfifo_feeder.sv
// Testbench for sdram_wfifo_feeder. Uses a reduced frame size so that full
// frames stay short while lines still wrap the 8-bit data ramp.
module tb_sdram_wfifo_feeder;

    localparam int H  = 300;
    localparam int V  = 12;
    localparam int DW = 8;
    localparam int CW = 10;

    logic          sclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ini_end = 1'b0;
    logic          vs_in = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          wfifo_full = 1'b0;
    logic          wfifo_en;
    logic [DW-1:0] wfifo_data;
    logic          line_done, frame_done, busy, err_ovf;
    logic [CW-1:0] col_cnt, row_cnt;

    sdram_wfifo_feeder #(.H_ACTIVE(H), .V_ACTIVE(V), .DW(DW), .CW(CW)) dut (
        .sclk(sclk), .rst_n(rst_n), .ini_end(ini_end), .vs_in(vs_in),
        .pix_valid(pix_valid), .pix_data(pix_data), .wfifo_full(wfifo_full),
        .wfifo_en(wfifo_en), .wfifo_data(wfifo_data), .line_done(line_done),
        .frame_done(frame_done), .col_cnt(col_cnt), .row_cnt(row_cnt),
        .busy(busy), .err_ovf(err_ovf)
    );

    always #5 sclk = ~sclk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          ld;
        logic          fd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0, failures = 0;
    int   push_cnt = 0, ld_cnt = 0, fd_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [DW-1:0] d, input int c);
`ifdef WFEED_TEST_PATTERN_EN
        return c[DW-1:0];
`else
        return d;
`endif
    endfunction

    always @(negedge sclk) begin
        if (wfifo_en) begin
            push_cnt++;
            if (line_done)  ld_cnt++;
            if (frame_done) fd_cnt++;
            if (sb.size() == 0) begin
                check_eq("sb_pending", wfifo_en, 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("push", {wfifo_data, line_done, frame_done}, mon_e);
            end
        end else begin
            check_eq("idle_strobes", {line_done, frame_done}, 0);
        end
    end

    task automatic step(input bit vs, input bit pv, input bit full, input logic [DW-1:0] d);
        vs_in      = vs;
        pix_valid  = pv;
        wfifo_full = full;
        pix_data   = d;
        @(posedge sclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0);
    endtask

    // Sends n pixels starting at col 0 row 0 with vs_in on the first one.
    task automatic run_pixels(input int n, input bit ramp, input int gap);
        int c = 0;
        int r = 0;
        logic [DW-1:0] d;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            d = ramp ? DW'(c) : DW'($urandom);
`ifdef WFEED_TEST_PATTERN_EN
            d = 8'hAA;
`endif
            e.d  = exp_data(d, c);
            e.ld = (c == H - 1);
            e.fd = (c == H - 1) && (r == V - 1);
            sb.push_back(e);
            step(i == 0, 1, 0, d);
            c++;
            if (c == H) begin
                c = 0;
                r = (r == V - 1) ? 0 : r + 1;
                idle(gap);
            end else if ($urandom_range(0, 9) == 0) begin
                idle($urandom_range(1, 3));
            end
        end
    endtask

    task automatic drain();
        idle(3);
        check_eq("sb_drained", sb.size(), 0);
    endtask

    int p0, l0, f0;

    initial begin
        // Reset
        idle(3);
        check_eq("rst_outs", {wfifo_en, wfifo_data, line_done, frame_done, busy, err_ovf}, 0);
        check_eq("rst_cnts", {col_cnt, row_cnt}, 0);

        // Init gating
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) step(i == 20, 1, 0, DW'($urandom));
        check_eq("gate_busy", busy, 0);
        ini_end = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 1, 0, DW'($urandom));
        check_eq("sof_busy", busy, 0);
        check_eq("gate_pushes", push_cnt, 0);
        run_pixels(4, 0, 0);
        check_eq("gate_col", col_cnt, 4);
        check_eq("gate_busy_on", busy, 1);
        drain();

        // Full frame with ramp data
        p0 = push_cnt; l0 = ld_cnt; f0 = fd_cnt;
        run_pixels(H * V, 1, 20);
        drain();
        check_eq("frame_pushes", push_cnt - p0, H * V);
        check_eq("frame_lines", ld_cnt - l0, V);
        check_eq("frame_done_cnt", fd_cnt - f0, 1);
        check_eq("frame_end_cnts", {col_cnt, row_cnt}, 0);
        check_eq("frame_end_busy", busy, 0);
        p0 = push_cnt;
        for (int i = 0; i < 5; i++) step(0, 1, 0, DW'($urandom));
        drain();
        check_eq("post_frame_ignored", push_cnt - p0, 0);

        // Overflow
        p0 = push_cnt;
        run_pixels(3 * H + 100, 0, 5);
        check_eq("ovf_pre_err", err_ovf, 0);
        step(0, 1, 1, DW'($urandom));
        check_eq("ovf_err", err_ovf, 1);
        check_eq("ovf_busy", busy, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, DW'($urandom));
        drain();
        check_eq("ovf_pushes", push_cnt - p0, 3 * H + 100);
        run_pixels(5, 0, 0);
        check_eq("ovf_restart_cnts", {col_cnt, row_cnt}, {10'd5, 10'd0});
        check_eq("ovf_err_sticky", err_ovf, 1);
        check_eq("ovf_restart_busy", busy, 1);
        drain();

        // Short frame followed by a complete frame
        l0 = ld_cnt; f0 = fd_cnt;
        run_pixels(10 * H + 20, 0, 3);
        check_eq("short_cnts", {col_cnt, row_cnt}, {10'd20, 10'd10});
        run_pixels(H * V, 0, 3);
        drain();
        check_eq("short_fd", fd_cnt - f0, 1);
        check_eq("short_ld", ld_cnt - l0, 10 + V);
        check_eq("short_err_kept", err_ovf, 1);

        // Reset mid-line
        run_pixels(150, 0, 0);
        rst_n = 1'b0;
        step(0, 1, 0, DW'($urandom));
        check_eq("mrst_en", wfifo_en, 0);
        check_eq("mrst_cnts", {col_cnt, row_cnt}, 0);
        check_eq("mrst_flags", {busy, err_ovf}, 0);
        rst_n = 1'b1;
        idle(2);
        run_pixels(3, 0, 0);
        drain();
        check_eq("mrst_restart_col", col_cnt, 3);

        // ini_end dropping mid-frame
        run_pixels(50, 0, 0);
        ini_end = 1'b0;
        p0 = push_cnt;
        for (int i = 0; i < 5; i++) step(0, 1, 0, DW'($urandom));
        drain();
        check_eq("ini_drop_busy", busy, 0);
        check_eq("ini_drop_pushes", push_cnt - p0, 1);
        ini_end = 1'b1;
        idle(2);
        l0 = ld_cnt;
        run_pixels(H, 0, 0);
        drain();
        check_eq("ini_back_ld", ld_cnt - l0, 1);
        check_eq("ini_back_cnts", {col_cnt, row_cnt}, {10'd0, 10'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
